// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default widths for the fetch stage
package fetch_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - program-memory handshake, redirect/stall and IR load bundle
interface instruction_fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [DATA_W-1:0] ir_ins;
  logic              ir_load;
  logic [ADDR_W-1:0] fetch_pc;

  modport master (
    output mem_req, mem_addr, ir_ins, ir_load, fetch_pc,
    input  mem_ack, mem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, ir_ins, ir_load, fetch_pc,
    output mem_ack, mem_rdata, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with redirect load (priority) and wrapping increment
module pc_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, memory request FSM, one-word hold buffer, IR feed
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] pc, pc_target, redirect, redirect_d, hold_pc, fetch_pc_q;
  logic              pc_load, pc_inc, buf_we, ir_we, ir_from_buf, ir_load_q;
  logic [DATA_W-1:0] hold_buf, ir_ins_q;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pc_load),
    .target (pc_target),
    .inc    (pc_inc),
    .pc     (pc)
  );

  assign bus.mem_req  = (state == FETCH) || (state == FLUSH);
  assign bus.mem_addr = pc;
  assign bus.ir_ins   = ir_ins_q;
  assign bus.ir_load  = ir_load_q;
  assign bus.fetch_pc = fetch_pc_q;

  always_comb begin
    state_d     = state;
    pc_load     = 1'b0;
    pc_target   = bus.branch_target;
    pc_inc      = 1'b0;
    redirect_d  = redirect;
    buf_we      = 1'b0;
    ir_we       = 1'b0;
    ir_from_buf = 1'b0;
    case (state)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.branch_taken) begin
          // Without an ack the request must stay stable, so park the target.
          if (bus.mem_ack) begin
            pc_load = 1'b1;
          end else begin
            redirect_d = bus.branch_target;
            state_d    = FLUSH;
          end
        end else if (bus.mem_ack) begin
          pc_inc = 1'b1;
          if (bus.stall) begin
            buf_we  = 1'b1;
            state_d = HOLD;
          end else begin
            ir_we = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.branch_taken) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end else if (!bus.stall) begin
          ir_we       = 1'b1;
          ir_from_buf = 1'b1;
          state_d     = FETCH;
        end
      end
      FLUSH: begin
        if (bus.branch_taken) redirect_d = bus.branch_target;
        if (bus.mem_ack) begin
          pc_load   = 1'b1;
          pc_target = bus.branch_taken ? bus.branch_target : redirect;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      redirect   <= '0;
      hold_buf   <= '0;
      hold_pc    <= '0;
      ir_ins_q   <= '0;
      ir_load_q  <= 1'b0;
      fetch_pc_q <= '0;
    end else begin
      state     <= state_d;
      redirect  <= redirect_d;
      ir_load_q <= ir_we;
      if (buf_we) begin
        hold_buf <= bus.mem_rdata;
        hold_pc  <= pc;
      end
      if (ir_we) begin
        ir_ins_q   <= ir_from_buf ? hold_buf : bus.mem_rdata;
        fetch_pc_q <= ir_from_buf ? hold_pc : pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - bench for instruction_fetch against a program-order reference model
module tb_instruction_fetch;

  localparam logic [7:0] RESET_PC0 = 8'h00;
  localparam logic [7:0] RESET_PC1 = 8'hFE;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();
  instruction_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();

  instruction_fetch #(.ADDR_W(8), .DATA_W(16), .RESET_PC(RESET_PC0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instruction_fetch #(.ADDR_W(8), .DATA_W(16), .RESET_PC(RESET_PC1)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int total = 0;
  int bad   = 0;
  int loads = 0;
  int mem_lat;
  bit chk_consec;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory: word at address a is 16'h1000+a, ack after mem_lat cycles of req (random if negative).
  bit prev_req = 0, prev_ack = 0;
  int age = 0, cur_lat = 0;
  always @(posedge clk) begin
    #1;
    if (!bus.mem_req) begin
      bus.mem_ack = 1'b0;
    end else begin
      if (!prev_req || prev_ack) begin
        age     = 0;
        cur_lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      end else begin
        age++;
      end
      bus.mem_ack = (age == cur_lat);
    end
    bus.mem_rdata = bus.mem_ack ? 16'h1000 + 16'(bus.mem_addr) : 16'($urandom);
    prev_req = bus.mem_req;
    prev_ack = bus.mem_ack;
  end

  bit prev_req1 = 0, prev_ack1 = 0;
  always @(posedge clk) begin
    #1;
    bus1.mem_ack   = bus1.mem_req && prev_req1 && !prev_ack1;
    bus1.mem_rdata = 16'h1000 + 16'(bus1.mem_addr);
    prev_req1 = bus1.mem_req;
    prev_ack1 = bus1.mem_ack;
  end

  logic [7:0] wrap_q[$];
  always @(negedge clk) begin
    if (rst_n && bus1.ir_load && wrap_q.size() < 4) wrap_q.push_back(bus1.fetch_pc);
  end

  // Reference: loads follow program order from RESET_PC; a branch makes its target the next load.
  logic [7:0] exp_pc = RESET_PC0;
  bit prev_load = 0, prev_stall = 0, pend = 0;
  logic [7:0] pend_addr = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc    = RESET_PC0;
      prev_load = 0;
      prev_stall = 0;
      pend      = 0;
    end else begin
      if (bus.ir_load) begin
        check_eq("ld_pc", bus.fetch_pc, exp_pc);
        check_eq("ld_ins", bus.ir_ins, 16'h1000 + 16'(exp_pc));
        check_eq("ld_after_nostall", prev_stall, 0);
        if (chk_consec) check_eq("ld_gap", prev_load, 0);
        exp_pc++;
        loads++;
      end
      if (bus.branch_taken) exp_pc = bus.branch_target;
      if (pend && bus.mem_req) check_eq("addr_stable", bus.mem_addr, pend_addr);
      pend       = bus.mem_req && !bus.mem_ack;
      pend_addr  = bus.mem_addr;
      prev_load  = bus.ir_load;
      prev_stall = bus.stall;
    end
  end

  initial begin
    int n;
    int ld0;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 8'h00;
    bus1.stall = 0; bus1.branch_taken = 0; bus1.branch_target = 8'h00;
    mem_lat = 1;
    chk_consec = 1;

    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_req", bus.mem_req, 0);
    check_eq("rst_addr", bus.mem_addr, RESET_PC0);
    check_eq("rst_load", bus.ir_load, 0);
    check_eq("rst_ins", bus.ir_ins, 0);
    check_eq("rst_fpc", bus.fetch_pc, 0);
    check_eq("rst_addr_wrap", bus1.mem_addr, RESET_PC1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_req", bus.mem_req, 0);
    step();
    @(negedge clk);
    check_eq("first_req", bus.mem_req, 1);
    check_eq("first_addr", bus.mem_addr, 8'h00);

    // Sequential fetch of words 0..2
    n = 0;
    while (loads < 3 && n < 40) begin step(); n++; end
    check_eq("t1_loads", loads >= 3, 1);

    // Stall from the ack of word 3 for 5 cycles
    n = 0;
    while (!(bus.mem_ack && bus.mem_addr == 8'h03) && n < 20) begin step(); n++; end
    check_eq("t2_ack3_seen", bus.mem_ack && bus.mem_addr == 8'h03, 1);
    bus.stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check_eq("hold_req", bus.mem_req, 0);
      check_eq("hold_load", bus.ir_load, 0);
    end
    step();
    bus.stall = 0;
    step();
    @(negedge clk);
    check_eq("rel_load", bus.ir_load, 1);
    check_eq("rel_ins", bus.ir_ins, 16'h1003);
    check_eq("rel_fpc", bus.fetch_pc, 8'h03);
    check_eq("rel_addr", bus.mem_addr, 8'h04);
    mem_lat = 4;

    // Branch two cycles into a 4-cycle wait on word 5
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 8'h05) && n < 20) begin step(); n++; end
    check_eq("t3_req5_seen", bus.mem_addr, 8'h05);
    step();
    step();
    bus.branch_taken = 1; bus.branch_target = 8'h40;
    mem_lat = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("br_addr_hold", bus.mem_addr, 8'h05);
      check_eq("br_req_hold", bus.mem_req, 1);
      step();
      bus.branch_taken = 0;
    end
    @(negedge clk);
    check_eq("br_new_addr", bus.mem_addr, 8'h40);
    check_eq("br_no_load", bus.ir_load, 0);
    n = 0;
    while (!bus.ir_load && n < 20) begin step(); n++; end
    check_eq("br_first_fpc", bus.fetch_pc, 8'h40);
    check_eq("br_first_ins", bus.ir_ins, 16'h1040);
    mem_lat = 4;

    // Three redirects while squashing word 0x42; the last one wins
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 8'h42) && n < 20) begin step(); n++; end
    check_eq("t4_req42_seen", bus.mem_addr, 8'h42);
    bus.branch_taken = 1; bus.branch_target = 8'h10;
    mem_lat = 1;
    step(); bus.branch_target = 8'h20;
    step(); bus.branch_target = 8'h30;
    step(); bus.branch_taken = 0;
    step();
    @(negedge clk);
    check_eq("flush_addr_hold", bus.mem_addr, 8'h42);
    step();
    @(negedge clk);
    check_eq("flush_refetch", bus.mem_addr, 8'h30);

    // Branch coincident with ack in FETCH
    n = 0;
    while (!(bus.mem_ack && bus.mem_addr == 8'h31) && n < 20) begin step(); n++; end
    check_eq("t4_ack31_seen", bus.mem_ack && bus.mem_addr == 8'h31, 1);
    bus.branch_taken = 1; bus.branch_target = 8'h60;
    step();
    bus.branch_taken = 0;
    @(negedge clk);
    check_eq("coin_addr", bus.mem_addr, 8'h60);
    check_eq("coin_discard", bus.ir_load, 0);
    n = 0;
    while (!bus.ir_load && n < 20) begin step(); n++; end
    check_eq("coin_first_fpc", bus.fetch_pc, 8'h60);

    // Wrap from RESET_PC=FE on the second instance
    check_eq("wrap_cnt", wrap_q.size(), 4);
    for (int i = 0; i < 4 && i < wrap_q.size(); i++)
      check_eq("wrap_fpc", wrap_q[i], 8'(RESET_PC1 + 8'(i)));

    // Asynchronous reset while in HOLD
    n = 0;
    while (!bus.mem_ack && n < 20) begin step(); n++; end
    bus.stall = 1;
    step();
    rst_n = 1'b0;
    #1;
    check_eq("arst_hold_req", bus.mem_req, 0);
    check_eq("arst_hold_addr", bus.mem_addr, RESET_PC0);
    check_eq("arst_hold_load", bus.ir_load, 0);
    check_eq("arst_hold_ins", bus.ir_ins, 0);
    check_eq("arst_hold_fpc", bus.fetch_pc, 0);
    bus.stall = 0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("arst_no_stale", bus.ir_load, 0);
      step();
    end
    n = 0;
    while (!bus.ir_load && n < 20) begin step(); n++; end
    check_eq("arst_restart_fpc", bus.fetch_pc, RESET_PC0);
    mem_lat = 3;

    // Asynchronous reset with a request outstanding
    n = 0;
    while (!(bus.mem_req && bus.mem_addr == 8'h02) && n < 30) begin step(); n++; end
    check_eq("t6_req2_seen", bus.mem_addr, 8'h02);
    rst_n = 1'b0;
    #1;
    check_eq("arst_fetch_req", bus.mem_req, 0);
    check_eq("arst_fetch_addr", bus.mem_addr, RESET_PC0);
    step();
    rst_n = 1'b1;
    mem_lat = 1;
    n = 0;
    while (!bus.ir_load && n < 30) begin step(); n++; end
    check_eq("arst2_restart_fpc", bus.fetch_pc, RESET_PC0);

    // Randomized stalls, branches and memory latency
    chk_consec = 0;
    mem_lat = -1;
    ld0 = loads;
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.stall         = ($urandom_range(0, 9) < 3);
      bus.branch_taken  = ($urandom_range(0, 19) == 0);
      bus.branch_target = 8'($urandom);
    end
    step();
    bus.stall = 0;
    bus.branch_taken = 0;
    repeat (20) step();
    check_eq("rand_progress", (loads - ld0) > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
